// File: rtl/dm_pkg.sv
// Shared constants for the debug-module abstract-command sequencer:
// ROM entry points, cmderr codes, command types and FSM state encoding.
package dm_pkg;

    localparam logic [9:0] ENTRY_SET_GPR = 10'h0D0;
    localparam logic [9:0] ENTRY_GET_GPR = 10'h0E0;
    localparam logic [9:0] ENTRY_SET_CSR = 10'h0F0;
    localparam logic [9:0] ENTRY_GET_CSR = 10'h104;
    localparam logic [9:0] ENTRY_SET_MEM = 10'h128;
    localparam logic [9:0] ENTRY_GET_MEM = 10'h144;

    localparam logic [7:0] CMDTYPE_REG = 8'd0;
    localparam logic [7:0] CMDTYPE_MEM = 8'd2;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXC        = 3'd3,
        CMDERR_HALTRESUME = 3'd4,
        CMDERR_OTHER      = 3'd7
    } cmderr_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GO   = 2'd1,
        ST_EXEC = 2'd2
    } state_e;

    typedef struct packed {
        logic [9:0]  entry;
        logic [11:0] fix_reg;
        logic [1:0]  fix_size;
        logic        notsup;
        logic        trivial;
        logic        is_mem;
    } decode_t;

endpackage

// File: rtl/dm_abscmd_decode.sv
// Combinational abstract-command decoder: cmd word -> ROM entry, patch fields, support check.
// DM_ABSCMD_MEM_EN enables decoding of access-memory commands (cmdtype 2).
module dm_abscmd_decode
    import dm_pkg::*;
(
    input  logic [31:0] cmd,
    output decode_t     dec
);

    logic [7:0]  cmdtype;
    logic [2:0]  size;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;

    assign cmdtype  = cmd[31:24];
    assign size     = cmd[22:20];
    assign postexec = cmd[18];
    assign transfer = cmd[17];
    assign write    = cmd[16];
    assign regno    = cmd[15:0];

    always_comb begin
        dec          = '0;
        dec.fix_size = size[1:0];
        // bit 23 is reserved; a set bit is treated like an unknown size encoding
        if (postexec || cmd[23]) begin
            dec.notsup = 1'b1;
        end else begin
            case (cmdtype)
                CMDTYPE_REG: begin
                    if (!transfer) begin
                        dec.trivial = 1'b1;
                    end else if (size > 3'd2) begin
                        dec.notsup = 1'b1;
                    end else if (regno[15:5] == 11'h080) begin
                        dec.fix_reg = {7'b0, regno[4:0]};
                        dec.entry   = write ? ENTRY_SET_GPR : ENTRY_GET_GPR;
                    end else if (regno[15:12] == 4'h0) begin
                        dec.fix_reg = regno[11:0];
                        dec.entry   = write ? ENTRY_SET_CSR : ENTRY_GET_CSR;
                    end else begin
                        dec.notsup = 1'b1;
                    end
                end
`ifdef DM_ABSCMD_MEM_EN
                CMDTYPE_MEM: begin
                    if (size > 3'd2) begin
                        dec.notsup = 1'b1;
                    end else begin
                        dec.is_mem = 1'b1;
                        dec.entry  = write ? ENTRY_SET_MEM : ENTRY_GET_MEM;
                    end
                end
`endif
                default: dec.notsup = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dm_abscmd_seq.sv
// Debug-module abstract-command sequencer: accepts command writes, drives the ROM go/going/done
// handshake, tracks sticky cmderr. DM_ABSCMD_MEM_EN enables access-memory commands and postinc_pulse.
module dm_abscmd_seq
    import dm_pkg::*;
#(
    parameter int unsigned WDOG_CYC = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_wr,
    input  logic [31:0] cmd,
    input  logic [2:0]  cmderr_w1c,
    input  logic        cmderr_clr,
    input  logic        hart_halted,
    input  logic        hart_going,
    input  logic        hart_done,
    input  logic        hart_exc,
    output logic        go,
    output logic        busy,
    output logic [2:0]  cmderr,
    output logic [9:0]  entry_addr,
    output logic [11:0] fix_reg,
    output logic [1:0]  fix_size,
    output logic [15:0] regno_q,
    output logic        postinc_pulse
);

    localparam int unsigned CW = $clog2(WDOG_CYC + 2);

    state_e      state, state_next;
    decode_t     dec;
    logic [CW-1:0] wdog_cnt;
    logic        wdog_expire;
    logic        postinc_q;
    logic        mem_q;
    logic        cmd_check;
    logic        accept;
    logic        trivial_ok;
    logic        finish_ok;
    logic        err_set;
    cmderr_e     err_code;
    logic [2:0]  cmderr_base;

    dm_abscmd_decode u_decode (
        .cmd (cmd),
        .dec (dec)
    );

    // a command write in IDLE is only considered while no error is pending
    assign cmd_check   = (state == ST_IDLE) && cmd_wr && (cmderr == 3'd0);
    assign accept      = cmd_check && !dec.notsup && hart_halted && !dec.trivial;
    assign trivial_ok  = cmd_check && !dec.notsup && hart_halted && dec.trivial;
    assign finish_ok   = (state == ST_EXEC) && hart_done && !hart_exc;
    assign wdog_expire = (WDOG_CYC != 0) && (state != ST_IDLE) &&
                         (wdog_cnt == CW'(WDOG_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_GO;
            ST_GO: begin
                if (hart_going)       state_next = ST_EXEC;
                else if (wdog_expire) state_next = ST_IDLE;
            end
            ST_EXEC: begin
                if (hart_exc || hart_done) state_next = ST_IDLE;
                else if (wdog_expire)      state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        go   = (state == ST_GO);
        busy = (state != ST_IDLE);
    end

    always_comb begin
        err_set  = 1'b0;
        err_code = CMDERR_NONE;
        if (cmd_check && dec.notsup) begin
            err_set  = 1'b1;
            err_code = CMDERR_NOTSUP;
        end else if (cmd_check && !hart_halted) begin
            err_set  = 1'b1;
            err_code = CMDERR_HALTRESUME;
        end else if (state == ST_EXEC && hart_exc) begin
            err_set  = 1'b1;
            err_code = CMDERR_EXC;
        end else if (wdog_expire && state_next == ST_IDLE) begin
            err_set  = 1'b1;
            err_code = CMDERR_OTHER;
        end else if (busy && cmd_wr) begin
            err_set  = 1'b1;
            err_code = CMDERR_BUSY;
        end
    end

    // a new error lands only when nothing remains pending after this cycle's clear
    assign cmderr_base = cmderr & ~(cmderr_clr ? cmderr_w1c : 3'b000);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cmderr <= '0;
        end else if (err_set && cmderr_base == 3'd0) begin
            cmderr <= err_code;
        end else begin
            cmderr <= cmderr_base;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || state == ST_IDLE || state_next != state) wdog_cnt <= '0;
        else                                                   wdog_cnt <= wdog_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            entry_addr <= '0;
            fix_reg    <= '0;
            fix_size   <= '0;
            postinc_q  <= 1'b0;
            mem_q      <= 1'b0;
            regno_q    <= '0;
        end else if (accept) begin
            entry_addr <= dec.entry;
            fix_reg    <= dec.fix_reg;
            fix_size   <= dec.fix_size;
            postinc_q  <= cmd[19];
            mem_q      <= dec.is_mem;
            regno_q    <= cmd[15:0];
        end else if (trivial_ok) begin
            regno_q    <= cmd[15:0] + {15'b0, cmd[19]};
        end else if (finish_ok && postinc_q && !mem_q) begin
            regno_q    <= regno_q + 16'd1;
        end
    end

`ifdef DM_ABSCMD_MEM_EN
    always_ff @(posedge clk) begin
        if (!rstn) postinc_pulse <= 1'b0;
        else       postinc_pulse <= finish_ok && postinc_q && mem_q;
    end
`else
    assign postinc_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_dm_abscmd_seq.sv
// Directed self-checking bench for dm_abscmd_seq (watchdog shortened to 16 cycles).
// Exercises the access-memory path when DM_ABSCMD_MEM_EN is defined.
module tb_dm_abscmd_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_wr;
    logic [31:0] cmd;
    logic [2:0]  cmderr_w1c;
    logic        cmderr_clr;
    logic        hart_halted;
    logic        hart_going;
    logic        hart_done;
    logic        hart_exc;
    logic        go;
    logic        busy;
    logic [2:0]  cmderr;
    logic [9:0]  entry_addr;
    logic [11:0] fix_reg;
    logic [1:0]  fix_size;
    logic [15:0] regno_q;
    logic        postinc_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_abscmd_seq #(.WDOG_CYC(16)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cmd_wr        (cmd_wr),
        .cmd           (cmd),
        .cmderr_w1c    (cmderr_w1c),
        .cmderr_clr    (cmderr_clr),
        .hart_halted   (hart_halted),
        .hart_going    (hart_going),
        .hart_done     (hart_done),
        .hart_exc      (hart_exc),
        .go            (go),
        .busy          (busy),
        .cmderr        (cmderr),
        .entry_addr    (entry_addr),
        .fix_reg       (fix_reg),
        .fix_size      (fix_size),
        .regno_q       (regno_q),
        .postinc_pulse (postinc_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_cmd(input logic [31:0] c);
        cmd    = c;
        cmd_wr = 1'b1;
        tick();
        cmd_wr = 1'b0;
    endtask

    task automatic pulse_going();
        hart_going = 1'b1;
        tick();
        hart_going = 1'b0;
    endtask

    task automatic pulse_done();
        hart_done = 1'b1;
        tick();
        hart_done = 1'b0;
    endtask

    task automatic clear_err(input logic [2:0] mask);
        cmderr_w1c = mask;
        cmderr_clr = 1'b1;
        tick();
        cmderr_clr = 1'b0;
        cmderr_w1c = 3'b000;
    endtask

    initial begin
        int pulses;
        rstn = 1'b0; cmd_wr = 1'b0; cmd = '0; cmderr_w1c = '0; cmderr_clr = 1'b0;
        hart_halted = 1'b0; hart_going = 1'b0; hart_done = 1'b0; hart_exc = 1'b0;
        tick(2);
        check("rst_busy",   busy, 0);
        check("rst_go",     go, 0);
        check("rst_cmderr", cmderr, 0);
        check("rst_entry",  entry_addr, 0);
        check("rst_regno",  regno_q, 0);
        check("rst_pulse",  postinc_pulse, 0);
        rstn = 1'b1;
        hart_halted = 1'b1;
        tick();

        // GPR write x5, word
        write_cmd(32'h0023_1005);
        check("gpr_busy",  busy, 1);
        check("gpr_go",    go, 1);
        check("gpr_entry", entry_addr, 10'h0D0);
        check("gpr_fix",   fix_reg, 12'h005);
        check("gpr_size",  fix_size, 2);
        tick(2);
        check("gpr_go_held", go, 1);
        pulse_going();
        check("gpr_go_drop", go, 0);
        check("gpr_exec_busy", busy, 1);
        pulse_done();
        check("gpr_done_busy", busy, 0);
        check("gpr_entry_stable", entry_addr, 10'h0D0);
        check("gpr_regno", regno_q, 16'h1005);

        // unsupported size
        write_cmd(32'h0032_0300);
        check("size3_err",  cmderr, 2);
        check("size3_busy", busy, 0);
        clear_err(3'b010);
        check("size3_clr", cmderr, 0);

        // CSR read with postinc
        write_cmd(32'h002A_0341);
        check("csr_entry", entry_addr, 10'h104);
        check("csr_fix",   fix_reg, 12'h341);
        pulse_going();
        pulse_done();
        check("csr_regno", regno_q, 16'h0342);
        check("csr_err",   cmderr, 0);

        // busy write during EXEC
        write_cmd(32'h0023_1005);
        pulse_going();
        write_cmd(32'h0022_1006);
        check("busywr_err",  cmderr, 1);
        check("busywr_busy", busy, 1);
        check("busywr_fix",  fix_reg, 12'h005);
        pulse_done();
        check("busywr_done", busy, 0);
        write_cmd(32'h0023_1007);
        check("ignored_busy", busy, 0);
        check("ignored_fix",  fix_reg, 12'h005);
        hart_exc = 1'b1; tick(); hart_exc = 1'b0;
        check("ignored_exc", cmderr, 1);
        clear_err(3'b111);
        check("busywr_clr", cmderr, 0);

        // exception and done in the same cycle: exception wins, no postinc
        write_cmd(32'h002A_0341);
        pulse_going();
        hart_exc = 1'b1; hart_done = 1'b1; tick(); hart_exc = 1'b0; hart_done = 1'b0;
        check("exc_err",   cmderr, 3);
        check("exc_busy",  busy, 0);
        check("exc_regno", regno_q, 16'h0341);
        clear_err(3'b011);

        // trivial command with postinc wraps regno
        write_cmd(32'h0008_FFFF);
        check("triv_busy",  busy, 0);
        check("triv_err",   cmderr, 0);
        check("triv_regno", regno_q, 16'h0000);

        // not halted
        hart_halted = 1'b0;
        write_cmd(32'h0023_1005);
        check("nohalt_err", cmderr, 4);
        check("nohalt_go",  go, 0);
        tick(3);
        check("nohalt_go_later", go, 0);
        check("nohalt_busy", busy, 0);
        hart_halted = 1'b1;
        clear_err(3'b100);

        // watchdog abort after 16 cycles in GO
        write_cmd(32'h0023_1005);
        tick(15);
        check("wdog_busy15", busy, 1);
        check("wdog_go15",   go, 1);
        tick();
        check("wdog_err",  cmderr, 7);
        check("wdog_go",   go, 0);
        check("wdog_busy", busy, 0);
        clear_err(3'b111);

`ifdef DM_ABSCMD_MEM_EN
        write_cmd(32'h0219_0000);
        check("mem_entry", entry_addr, 10'h128);
        check("mem_size",  fix_size, 1);
        check("mem_fix",   fix_reg, 0);
        pulse_going();
        pulse_done();
        pulses = int'(postinc_pulse);
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(postinc_pulse);
        end
        check("mem_pulses", pulses, 1);
`else
        write_cmd(32'h0219_0000);
        check("mem_notsup", cmderr, 2);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(postinc_pulse);
        end
        check("mem_nopulse", pulses, 0);
        clear_err(3'b111);
`endif

        // reset mid-command
        write_cmd(32'h0023_1005);
        rstn = 1'b0;
        tick();
        check("midrst_go",    go, 0);
        check("midrst_busy",  busy, 0);
        check("midrst_entry", entry_addr, 0);
        rstn = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
